// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART blocks.
//   - uart_state_e : receiver FSM state encoding
//   - OVERSAMPLE   : ticks per bit period
//   - SAMPLE_MID   : centre tick of a bit; majority vote uses SAMPLE_MID-1..SAMPLE_MID+1
//   - calc_divisor : clocks per oversample tick, rounded to nearest (shared with TX side)
package uart_pkg;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned SAMPLE_MID = 8;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StBreak
   } uart_state_e;

   function automatic int unsigned calc_divisor(input int unsigned clk_freq,
                                                input int unsigned baud);
      return (clk_freq + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with registered occupancy count.
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous reset, active-high; empties the FIFO
//   wr_en_i    push wr_data_i (dropped when full unless a pop happens in the same clk)
//   wr_data_i  write data
//   rd_en_i    pop head entry; ignored when empty
//   rd_data_o  head entry, zero while empty
//   empty_o    no entries
//   full_o     DEPTH entries
//   count_o    current occupancy
// DEPTH must be a power of two, minimum 2.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     wr_en_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     rd_en_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);
   localparam logic [AW:0] CountOne = (AW + 1)'(1);
   localparam logic [AW-1:0] PtrOne = AW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   // A pop frees a slot in the same clk, so push-while-full succeeds when paired with a pop.
   always_comb begin
      do_pop  = rd_en_i && (count_q != '0);
      do_push = wr_en_i && ((count_q != FullCount) || do_pop);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
         if (do_push && !do_pop) begin
            count_q <= count_q + CountOne;
         end else if (do_pop && !do_push) begin
            count_q <= count_q - CountOne;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
   end

   always_comb begin
      empty_o   = (count_q == '0);
      full_o    = (count_q == FullCount);
      count_o   = count_q;
      rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver, 16x oversampling, FWFT receive FIFO.
// Optional feature: define UART_RX_PARITY_EN for 8E1 framing with a parity check.
// Ports:
//   clk         clock, rising edge
//   rst         synchronous reset, active-high; aborts any frame and empties the FIFO
//   rxd         asynchronous serial input, idle high
//   rd_en       pop head entry; ignored when rd_valid=0
//   rd_data     FIFO head byte
//   rd_valid    FIFO not empty
//   fifo_count  FIFO occupancy
//   overrun     sticky: byte dropped because the FIFO was full
//   frame_err   sticky: bad stop bit (or parity mismatch)
//   clr_err     clears overrun and frame_err; a same-clk error event wins
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQUENCY = 24000000,
   parameter int unsigned BAUD_RATE     = 115200,
   parameter int unsigned FIFO_DEPTH    = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rxd,
   input  logic                          rd_en,
   output logic [7:0]                    rd_data,
   output logic                          rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overrun,
   output logic                          frame_err,
   input  logic                          clr_err
);

   localparam int unsigned DIV = calc_divisor(CLK_FREQUENCY, BAUD_RATE);
   localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned TW  = $clog2(OVERSAMPLE);

   localparam logic [DW-1:0] DivLast   = DW'(DIV - 1);
   localparam logic [DW-1:0] DivOne    = DW'(1);
   localparam logic [TW-1:0] TickOne   = TW'(1);
   localparam logic [TW-1:0] TickEarly = TW'(SAMPLE_MID - 1);
   localparam logic [TW-1:0] TickMid   = TW'(SAMPLE_MID);
   localparam logic [TW-1:0] TickLate  = TW'(SAMPLE_MID + 1);
   localparam logic [TW-1:0] TickLast  = TW'(OVERSAMPLE - 1);

   logic [1:0]    sync_q;
   logic          rxd_s;
   uart_state_e   state_q;
   logic [DW-1:0] div_q;
   logic [TW-1:0] tick_idx_q;
   logic [2:0]    bit_idx_q;
   logic [7:0]    shift_q;
   logic [1:0]    samp_q;      // [1] = tick 7 sample, [0] = tick 8 sample
   logic          push_q;
   logic          frame_err_q;
   logic          overrun_q;
   logic          tick;
   logic          maj;
   logic          fifo_full;
   logic          fifo_empty;
`ifdef UART_RX_PARITY_EN
   logic          par_err_q;
`endif

   // Two-stage synchroniser; resets to the idle level so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) sync_q <= 2'b11;
      else     sync_q <= {sync_q[0], rxd};
   end

   always_comb begin
      rxd_s = sync_q[1];
      tick  = (state_q != StIdle) && (state_q != StBreak) && (div_q == DivLast);
      // Majority of ticks 7, 8 and the live sample at tick 9.
      maj   = (samp_q[1] & samp_q[0]) | ((samp_q[1] | samp_q[0]) & rxd_s);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         div_q       <= '0;
         tick_idx_q  <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         samp_q      <= 2'b11;
         push_q      <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err_q   <= 1'b0;
`endif
      end else begin
         push_q <= 1'b0;
         if (clr_err) frame_err_q <= 1'b0;

         // Tick generator: parked at zero while idle, so each frame is timed from its edge.
         if (state_q == StIdle || state_q == StBreak) begin
            div_q      <= '0;
            tick_idx_q <= '0;
         end else if (tick) begin
            div_q      <= '0;
            tick_idx_q <= tick_idx_q + TickOne;
         end else begin
            div_q <= div_q + DivOne;
         end

         if (tick && tick_idx_q == TickEarly) samp_q[1] <= rxd_s;
         if (tick && tick_idx_q == TickMid)   samp_q[0] <= rxd_s;

         case (state_q)
            StIdle: begin
               if (!rxd_s) begin
                  state_q   <= StStart;
                  bit_idx_q <= '0;
`ifdef UART_RX_PARITY_EN
                  par_err_q <= 1'b0;
`endif
               end
            end
            StStart: begin
               if (tick) begin
                  if (tick_idx_q == TickLate && maj) begin
                     state_q <= StIdle;   // glitch, not a start bit
                  end else if (tick_idx_q == TickLast) begin
                     state_q <= StData;
                  end
               end
            end
            StData: begin
               if (tick) begin
                  if (tick_idx_q == TickLate) shift_q <= {maj, shift_q[7:1]};
                  if (tick_idx_q == TickLast) begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                     if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_q <= StParity;
`else
                        state_q <= StStop;
`endif
                     end
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
               if (tick) begin
                  // Even parity: parity bit equals the XOR of the data bits.
                  if (tick_idx_q == TickLate && (maj != ^shift_q)) begin
                     par_err_q   <= 1'b1;
                     frame_err_q <= 1'b1;
                  end
                  if (tick_idx_q == TickLast) state_q <= StStop;
               end
            end
`endif
            StStop: begin
               // Leave at tick 9 so a back-to-back start edge is not missed.
               if (tick && tick_idx_q == TickLate) begin
                  if (maj) begin
`ifdef UART_RX_PARITY_EN
                     push_q <= !par_err_q;
`else
                     push_q <= 1'b1;
`endif
                     state_q <= StIdle;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= StBreak;
                  end
               end
            end
            StBreak: begin
               // Hold off until the line returns high so a held-low line does not re-trigger.
               if (rxd_s) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overrun_q <= 1'b0;
      end else if (push_q && fifo_full && !rd_en) begin
         overrun_q <= 1'b1;
      end else if (clr_err) begin
         overrun_q <= 1'b0;
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk),
      .rst_i     (rst),
      .wr_en_i   (push_q),
      .wr_data_i (shift_q),
      .rd_en_i   (rd_en),
      .rd_data_o (rd_data),
      .empty_o   (fifo_empty),
      .full_o    (fifo_full),
      .count_o   (fifo_count)
   );

   always_comb begin
      rd_valid  = !fifo_empty;
      overrun   = overrun_q;
      frame_err = frame_err_q;
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo (FIFO_DEPTH=4, default clock/baud).
// Honours UART_RX_PARITY_EN when defined (sends 8E1 frames, adds a parity-error case).
module tb_uart_rx_fifo;

   localparam int unsigned CLK_FREQUENCY = 24000000;
   localparam int unsigned BAUD_RATE     = 115200;
   localparam int unsigned FIFO_DEPTH    = 4;
   localparam int unsigned DIV      = (CLK_FREQUENCY + 8 * BAUD_RATE) / (16 * BAUD_RATE);
   localparam int unsigned BIT_CLKS = 16 * DIV;
`ifdef UART_RX_PARITY_EN
   localparam int unsigned NBITS = 11;
`else
   localparam int unsigned NBITS = 10;
`endif
   // Edge (counted from the start-edge drive) at which the FIFO takes a received byte:
   // 2 sync + 1 detect, stop-bit tick 9, then one clk to push.
   localparam int unsigned PUSH_EDGE = 3 + DIV * (16 * (NBITS - 1) + 10) + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       rxd;
   logic       rd_en;
   logic       clr_err;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic [2:0] fifo_count;
   logic       overrun;
   logic       frame_err;
`ifdef UART_RX_PARITY_EN
   logic       par_flip = 1'b0;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int lat;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic       exp_ferr;
   } vec_t;
   vec_t vecs[6];

   uart_rx_fifo #(
      .CLK_FREQUENCY (CLK_FREQUENCY),
      .BAUD_RATE     (BAUD_RATE),
      .FIFO_DEPTH    (FIFO_DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rxd        (rxd),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .fifo_count (fifo_count),
      .overrun    (overrun),
      .frame_err  (frame_err),
      .clr_err    (clr_err)
   );

   always #5 clk = ~clk;

   initial begin
      #(10 * 95000);
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      rxd = 1'b0;
      step(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         step(BIT_CLKS);
      end
`ifdef UART_RX_PARITY_EN
      rxd = (^d) ^ par_flip;
      step(BIT_CLKS);
`endif
      rxd = stop;
      step(BIT_CLKS);
      rxd = 1'b1;
   endtask

   // Pop pulse timed to coincide with the push clk of a frame started in parallel.
   task automatic pop_at_push();
      repeat (PUSH_EDGE - 1) @(posedge clk);
      #1 rd_en = 1'b1;
      step(1);
      rd_en = 1'b0;
   endtask

   task automatic pop_expect(input string name, input logic [7:0] d);
      check({name, " valid"}, rd_valid, 1'b1);
      check({name, " data"}, rd_data, d);
      rd_en = 1'b1;
      step(1);
      rd_en = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      step(1);
      clr_err = 1'b0;
   endtask

   initial begin
      vecs[0] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h00, exp_ferr: 1'b0};
      vecs[1] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hFF, exp_ferr: 1'b0};
      vecs[2] = '{data: 8'hA5, stop: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_ferr: 1'b1};
      vecs[3] = '{data: 8'h3C, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h3C, exp_ferr: 1'b0};
      vecs[4] = '{data: 8'h80, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h80, exp_ferr: 1'b0};
      vecs[5] = '{data: 8'h01, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h01, exp_ferr: 1'b0};

      rst = 1'b1; rxd = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
      step(5);
      check("reset rd_valid", rd_valid, 1'b0);
      check("reset count", fifo_count, 3'd0);
      check("reset rd_data", rd_data, 8'h00);
      check("reset overrun", overrun, 1'b0);
      check("reset frame_err", frame_err, 1'b0);
      rst = 1'b0;
      step(10);

      // Single byte with latency bound from the start edge.
      lat = 0;
      fork
         send_frame(8'h55, 1'b1);
         begin
            for (int n = 1; n <= 10 * BIT_CLKS + 4; n++) begin
               @(posedge clk);
               #1;
               if (rd_valid) begin
                  lat = n;
                  break;
               end
            end
         end
      join
      check("0x55 latency in bound", (lat > 0) && (lat <= 10 * BIT_CLKS + 4), 1'b1);
      check("0x55 count", fifo_count, 3'd1);
      pop_expect("0x55", 8'h55);
      check("after pop count", fifo_count, 3'd0);
      step(20);

      // Short low glitch on an idle line.
      rxd = 1'b0;
      step(3);
      rxd = 1'b1;
      step(10 * DIV + 20);
      check("glitch count", fifo_count, 3'd0);
      check("glitch frame_err", frame_err, 1'b0);
      check("glitch overrun", overrun, 1'b0);

      for (int v = 0; v < 6; v++) begin
         send_frame(vecs[v].data, vecs[v].stop);
         step(6);
         check($sformatf("vec%0d valid", v), rd_valid, vecs[v].exp_valid);
         check($sformatf("vec%0d count", v), fifo_count, {2'b00, vecs[v].exp_valid});
         check($sformatf("vec%0d frame_err", v), frame_err, vecs[v].exp_ferr);
         if (vecs[v].exp_valid) pop_expect($sformatf("vec%0d", v), vecs[v].exp_data);
         if (vecs[v].exp_ferr) begin
            pulse_clr();
            check($sformatf("vec%0d clr frame_err", v), frame_err, 1'b0);
         end
         step(20);
      end

      // clr_err in the same clk as a stop-bit error: the error wins.
      fork
         send_frame(8'h5A, 1'b0);
         begin
            repeat (PUSH_EDGE - 2) @(posedge clk);
            #1 clr_err = 1'b1;
            step(1);
            clr_err = 1'b0;
         end
      join
      step(6);
      check("clr vs set frame_err", frame_err, 1'b1);
      pulse_clr();
      step(20);

      // Back-to-back fill past capacity.
      for (int d = 1; d <= 5; d++) send_frame(8'(d), 1'b1);
      step(6);
      check("full count", fifo_count, 3'd4);
      check("full overrun", overrun, 1'b1);
      check("full head", rd_data, 8'h01);
      pulse_clr();
      check("clr overrun", overrun, 1'b0);
      check("clr frame_err", frame_err, 1'b0);

      // Push and pop in the same clk while full.
      fork
         send_frame(8'h06, 1'b1);
         pop_at_push();
      join
      step(6);
      check("full push+pop overrun", overrun, 1'b0);
      check("full push+pop count", fifo_count, 3'd4);
      pop_expect("drain0", 8'h02);
      pop_expect("drain1", 8'h03);
      pop_expect("drain2", 8'h04);
      pop_expect("drain3 tail", 8'h06);
      check("drained valid", rd_valid, 1'b0);
      step(20);

      // Push and pop in the same clk while empty: only the push takes effect.
      fork
         send_frame(8'hC3, 1'b1);
         pop_at_push();
      join
      step(6);
      check("empty push+pop count", fifo_count, 3'd1);
      pop_expect("empty push+pop", 8'hC3);
      step(20);

      // Reset mid-frame with a stored byte and a set flag.
      send_frame(8'h11, 1'b1);
      step(20);
      send_frame(8'h22, 1'b0);
      step(20);
      check("pre-reset count", fifo_count, 3'd1);
      check("pre-reset frame_err", frame_err, 1'b1);
      rxd = 1'b0;
      step(BIT_CLKS);
      for (int i = 0; i < 4; i++) begin
         rxd = i[0] ? 1'b0 : (i == 0);   // bits 0..3 of 0x81
         step(BIT_CLKS);
      end
      rxd = 1'b0;                         // bit 4 of 0x81
      step(BIT_CLKS / 2);
      rst = 1'b1;
      rxd = 1'b1;
      step(3);
      check("mid-frame rst count", fifo_count, 3'd0);
      check("mid-frame rst valid", rd_valid, 1'b0);
      check("mid-frame rst frame_err", frame_err, 1'b0);
      rst = 1'b0;
      step(20);
      send_frame(8'h7E, 1'b1);
      step(6);
      check("post-reset count", fifo_count, 3'd1);
      pop_expect("post-reset", 8'h7E);
      step(2 * BIT_CLKS);
      check("post-reset nothing else", fifo_count, 3'd0);

`ifdef UART_RX_PARITY_EN
      par_flip = 1'b1;
      send_frame(8'h7E, 1'b1);
      par_flip = 1'b0;
      step(6);
      check("parity err frame_err", frame_err, 1'b1);
      check("parity err count", fifo_count, 3'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
